// File: rtl/tdcomp_sequencer.sv
// Burst sequencer for the time-domain comparator: precharge, launch, race-detect,
// and majority-vote the per-trial winners into one registered decision.
module tdcomp_sequencer #(
  parameter int PRECH_CYC   = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] trials,
  input  logic             arr_p,
  input  logic             arr_n,
  output logic             prech,
  output logic             fire,
  output logic             busy,
  output logic             done,
  output logic             decision,
  output logic             tie,
  output logic [CNT_W-1:0] p_votes,
  output logic [CNT_W-1:0] n_votes
);

  localparam int TMR_MAX = (PRECH_CYC > TIMEOUT_CYC) ? PRECH_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PRECH_LAST = TMR_W'(PRECH_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] ARM_LAST   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECH,
    S_FIRE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync_meta;
  logic [1:0]       r_sync;
  logic             r_start_d;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_trials_left;
  logic [CNT_W-1:0] r_p_cnt;
  logic [CNT_W-1:0] r_n_cnt;
  logic             r_prech;
  logic             r_fire;
  logic             r_busy;
  logic             r_done;
  logic             r_decision;
  logic             r_tie;
  logic [CNT_W-1:0] r_p_votes;
  logic [CNT_W-1:0] r_n_votes;

  logic [1:0]       w_arr;
  logic             w_sp;
  logic             w_sn;
  logic             w_start_acc;
  logic             w_in_wait;
  logic             w_vote_p;
  logic             w_vote_n;
  logic             w_both;
  logic             w_timeout;
  logic             w_trial_end;
  logic             w_last_trial;
  logic [CNT_W-1:0] w_p_final;
  logic [CNT_W-1:0] w_n_final;
  logic [CNT_W-1:0] w_trials_eff;

  assign w_arr = {arr_n, arr_p};

  // Two-flop synchronizer per asynchronous arrival flag (bit 0 = P, bit 1 = N).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sync_meta[gi] <= 1'b0;
          r_sync[gi]      <= 1'b0;
        end else begin
          r_sync_meta[gi] <= w_arr[gi];
          r_sync[gi]      <= r_sync_meta[gi];
        end
      end
    end
  endgenerate

  assign w_sp = r_sync[0];
  assign w_sn = r_sync[1];

  assign w_start_acc  = start && !r_start_d && (r_state == S_IDLE);
  assign w_trials_eff = (trials == '0) ? CNT_ONE : trials;

  assign w_in_wait    = (r_state == S_WAIT);
  assign w_vote_p     = w_in_wait && w_sp && !w_sn;
  assign w_vote_n     = w_in_wait && w_sn && !w_sp;
  assign w_both       = w_in_wait && w_sp && w_sn;
  assign w_timeout    = w_in_wait && !w_sp && !w_sn && (r_timer == WAIT_LAST);
  assign w_trial_end  = w_vote_p || w_vote_n || w_both || w_timeout;
  assign w_last_trial = (r_trials_left == CNT_ONE);

  // Final counts include this cycle's vote so the result registers with done.
  assign w_p_final = (w_vote_p && (r_p_cnt != CNT_MAX)) ? r_p_cnt + CNT_ONE : r_p_cnt;
  assign w_n_final = (w_vote_n && (r_n_cnt != CNT_MAX)) ? r_n_cnt + CNT_ONE : r_n_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_start_d     <= 1'b0;
      r_timer       <= '0;
      r_trials_left <= '0;
      r_p_cnt       <= '0;
      r_n_cnt       <= '0;
      r_prech       <= 1'b1;
      r_fire        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_decision    <= 1'b0;
      r_tie         <= 1'b0;
      r_p_votes     <= '0;
      r_n_votes     <= '0;
    end else begin
      r_start_d <= start;
      r_fire    <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_prech <= 1'b1;
          if (w_start_acc) begin
            r_trials_left <= w_trials_eff;
            r_p_cnt       <= '0;
            r_n_cnt       <= '0;
            r_timer       <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_PRECH;
          end
        end
        S_PRECH: begin
          if (r_timer == PRECH_LAST) begin
            r_timer <= '0;
            r_prech <= 1'b0;
            r_fire  <= 1'b1;
            r_state <= S_FIRE;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        S_FIRE: begin
          r_timer <= '0;
          r_state <= S_ARM;
        end
        S_ARM: begin
          if (r_timer == ARM_LAST) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        S_WAIT: begin
          r_p_cnt <= w_p_final;
          r_n_cnt <= w_n_final;
          if (w_trial_end) begin
            r_timer       <= '0;
            r_prech       <= 1'b1;
            r_trials_left <= r_trials_left - CNT_ONE;
            if (w_last_trial) begin
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_decision <= (w_p_final > w_n_final);
              r_tie      <= (w_p_final == w_n_final);
              r_p_votes  <= w_p_final;
              r_n_votes  <= w_n_final;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_PRECH;
            end
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        S_DONE: begin
          r_prech <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_prech <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign prech    = r_prech;
  assign fire     = r_fire;
  assign busy     = r_busy;
  assign done     = r_done;
  assign decision = r_decision;
  assign tie      = r_tie;
  assign p_votes  = r_p_votes;
  assign n_votes  = r_n_votes;

endmodule

// File: tb/tb_tdcomp_sequencer.sv
// Directed bench for tdcomp_sequencer: latency, voting, timeout, ignore rules,
// reset abort and back-to-back bursts, all with hand-derived expectations.
module tb_tdcomp_sequencer;

  localparam int PRECH_CYC   = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] trials = '0;
  logic             arr_p = 1'b0;
  logic             arr_n = 1'b0;
  logic             prech;
  logic             fire;
  logic             busy;
  logic             done;
  logic             decision;
  logic             tie;
  logic [CNT_W-1:0] p_votes;
  logic [CNT_W-1:0] n_votes;

  int checks = 0;
  int failures = 0;

  tdcomp_sequencer #(
    .PRECH_CYC  (PRECH_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .trials  (trials),
    .arr_p   (arr_p),
    .arr_n   (arr_n),
    .prech   (prech),
    .fire    (fire),
    .busy    (busy),
    .done    (done),
    .decision(decision),
    .tie     (tie),
    .p_votes (p_votes),
    .n_votes (n_votes)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    trials = CNT_W'(n);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_fire(output int pc);
    bit ok;
    ok = 1'b0;
    pc = 0;
    for (int i = 0; i < 50; i++) begin
      if (fire) begin
        ok = 1'b1;
        break;
      end
      if (prech) pc++;
      tick();
    end
    chk("fire_seen", ok, 1);
  endtask

  // From the fire cycle: raise flags dly cycles later, run until prech returns.
  task automatic finish_trial(input bit p, input bit n, input int dly, input int budget,
                              output int low);
    bit ok;
    ok  = 1'b0;
    low = 0;
    for (int i = 0; i < budget; i++) begin
      if (prech) begin
        ok = 1'b1;
        break;
      end
      low++;
      if (i == dly) begin
        arr_p = p;
        arr_n = n;
      end
      tick();
    end
    chk("trial_end_seen", ok, 1);
    arr_p = 1'b0;
    arr_n = 1'b0;
  endtask

  task automatic do_trial(input bit p, input bit n, input int dly, input int budget,
                          output int low);
    int pc;
    wait_fire(pc);
    chk("prech_cycles", pc, PRECH_CYC);
    finish_trial(p, n, dly, budget, low);
  endtask

  initial begin
    int  lc;
    int  cnt;
    int  fcnt;
    bit  pat [5];

    $display("TB step: reset");
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_prech", prech, 1);
    chk("rst_fire", fire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_decision", decision, 0);
    chk("rst_tie", tie, 0);
    chk("rst_p_votes", p_votes, 0);
    chk("rst_n_votes", n_votes, 0);
    rst_n = 1'b1;
    tick();

    $display("TB step: single P win with cycle-exact latency");
    do_start(1);                       // cycle 1
    chk("p1_busy_c1", busy, 1);
    chk("p1_prech_c1", prech, 1);
    chk("p1_fire_c1", fire, 0);
    repeat (3) tick();                 // cycle 4
    chk("p1_prech_c4", prech, 1);
    tick();                            // cycle 5
    chk("p1_fire_c5", fire, 1);
    chk("p1_prech_c5", prech, 0);
    tick();                            // cycle 6
    chk("p1_fire_c6", fire, 0);
    repeat (4) tick();                 // cycle 10
    arr_p = 1'b1;
    tick();                            // cycle 11
    chk("p1_done_c11", done, 0);
    tick();                            // cycle 12
    chk("p1_done_c12", done, 0);
    tick();                            // cycle 13
    chk("p1_done_c13", done, 1);
    chk("p1_busy_c13", busy, 0);
    chk("p1_prech_c13", prech, 1);
    chk("p1_decision", decision, 1);
    chk("p1_tie", tie, 0);
    chk("p1_p_votes", p_votes, 1);
    chk("p1_n_votes", n_votes, 0);
    arr_p = 1'b0;
    tick();                            // cycle 14, IDLE
    chk("p1_done_c14", done, 0);
    chk("p1_decision_held", decision, 1);

    $display("TB step: back-to-back burst, N win");
    do_start(1);
    chk("b2b_busy", busy, 1);
    chk("b2b_decision_held", decision, 1);
    chk("b2b_p_votes_held", p_votes, 1);
    do_trial(1'b0, 1'b1, 4, 20, lc);
    chk("b2b_low_cycles", lc, 7);
    chk("b2b_done", done, 1);
    chk("b2b_decision", decision, 0);
    chk("b2b_tie", tie, 0);
    chk("b2b_p_votes", p_votes, 0);
    chk("b2b_n_votes", n_votes, 1);
    tick();

    $display("TB step: majority of 5, pattern N,P,N,N,P");
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_start(5);
    for (int t = 0; t < 5; t++) begin
      do_trial(pat[t], !pat[t], 4, 20, lc);
      chk("maj_low_cycles", lc, 7);
      chk("maj_done_flag", done, (t == 4) ? 1 : 0);
    end
    chk("maj_decision", decision, 0);
    chk("maj_tie", tie, 0);
    chk("maj_p_votes", p_votes, 2);
    chk("maj_n_votes", n_votes, 3);
    tick();

    $display("TB step: reset asserted during WAIT");
    do_start(1);
    wait_fire(lc);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("rwait_busy", busy, 0);
    chk("rwait_prech", prech, 1);
    chk("rwait_done", done, 0);
    chk("rwait_n_votes", n_votes, 0);
    rst_n = 1'b1;
    cnt  = 0;
    fcnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) cnt++;
      if (fire) fcnt++;
    end
    chk("rwait_no_done", cnt, 0);
    chk("rwait_no_fire", fcnt, 0);

    $display("TB step: two timeouts");
    do_start(2);
    do_trial(1'b0, 1'b0, 1000, 100, lc);
    chk("to1_low_cycles", lc, 3 + TIMEOUT_CYC);
    chk("to1_done", done, 0);
    do_trial(1'b0, 1'b0, 1000, 100, lc);
    chk("to2_low_cycles", lc, 3 + TIMEOUT_CYC);
    chk("to_done", done, 1);
    chk("to_tie", tie, 1);
    chk("to_decision", decision, 0);
    chk("to_p_votes", p_votes, 0);
    chk("to_n_votes", n_votes, 0);
    tick();

    $display("TB step: P then simultaneous arrivals");
    do_start(2);
    do_trial(1'b1, 1'b0, 4, 20, lc);
    do_trial(1'b1, 1'b1, 4, 20, lc);
    chk("both_low_cycles", lc, 7);
    chk("both_done", done, 1);
    chk("both_decision", decision, 1);
    chk("both_tie", tie, 0);
    chk("both_p_votes", p_votes, 1);
    chk("both_n_votes", n_votes, 0);
    tick();

    $display("TB step: ignore rules, trials=0, start held");
    trials = '0;
    start  = 1'b1;
    tick();                            // cycle 1
    tick();                            // cycle 2
    arr_p = 1'b1;
    tick();                            // cycle 3
    start = 1'b0;
    tick();                            // cycle 4
    start = 1'b1;
    tick();                            // cycle 5
    chk("ign_fire_c5", fire, 1);
    arr_p = 1'b0;
    finish_trial(1'b0, 1'b1, 4, 20, lc);
    chk("ign_low_cycles", lc, 7);
    chk("ign_done", done, 1);
    chk("ign_p_votes", p_votes, 0);
    chk("ign_n_votes", n_votes, 1);
    chk("ign_decision", decision, 0);
    cnt  = 0;
    fcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) cnt++;
      if (fire) fcnt++;
    end
    chk("ign_no_relaunch_busy", cnt, 0);
    chk("ign_no_relaunch_fire", fcnt, 0);
    start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdcomp_sequencer.md
Name: tdcomp_sequencer

Overview:
Digital sequencer for the time-domain comparator macro. It runs a burst of comparison trials: precharge the two delay lines, fire the launch edge, then race-detect which line's arrival flag rises first. Per-trial winners are majority-voted into one decision. It sits between the tile's ui_in/uo_out pins and the comparator's analog control and arrival signals.

Parameters:
PRECH_CYC, 4, cycles prech is held high per trial (>=1)
TIMEOUT_CYC, 64, WAIT cycles before a trial is declared a timeout (>=4)
CNT_W, 4, width of the trials input and of the vote counters

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  level; rising edge (sampled in clk) launches a burst while idle
trials  input  CNT_W  trials per burst, sampled on accepted start; 0 is treated as 1
arr_p  input  1  asynchronous arrival flag, P delay line; stays high until precharge
arr_n  input  1  asynchronous arrival flag, N delay line; stays high until precharge
prech  output  1  delay-line precharge/reset to the comparator
fire  output  1  one-cycle launch pulse to both delay lines
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the burst result is valid
decision  output  1  1 = P won the majority; held until the next done
tie  output  1  votes equal, or every trial timed out; held with decision
p_votes  output  CNT_W  P wins in the last burst; held
n_votes  output  CNT_W  N wins in the last burst; held

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. prech=1 (lines parked discharged). fire, busy, done, decision, tie=0. Vote counters=0. Synchronizers, start-edge register and trial counter=0. Reset mid-burst aborts immediately with no done.
- arr_p/arr_n each pass through a 2-flop synchronizer (sp, sn). Only synchronized values are used.
- start edge detect: accepted when start=1, previous start=0 and state=IDLE. Edges seen while busy are ignored and not queued.
- FSM:
  IDLE: prech=1. On accepted start: latch trials (0->1), clear both vote counters, busy=1, go PRECH.
  PRECH: prech=1 for exactly PRECH_CYC cycles, then go FIRE. Arrivals are ignored.
  FIRE: prech=0, fire=1 for one cycle, go ARM.
  ARM: 2 cycles with prech=0, covering synchronizer flush; arrivals ignored; go WAIT. The WAIT timer starts at 0.
  WAIT: prech=0, timer increments each cycle.
    - sp=1, sn=0: p_votes+1.
    - sn=1, sp=0: n_votes+1.
    - both first seen in the same cycle: no vote (trial tie).
    - timer reaches TIMEOUT_CYC-1 with neither flag set: no vote (timeout).
    - After any of these four outcomes, decrement the remaining-trial count. If the remainder is nonzero go PRECH, else go DONE.
  DONE: one cycle. done=1, busy=0 at this cycle's output. Register decision = (p_votes > n_votes) and tie = (p_votes == n_votes), using the final counts. prech returns to 1. Go IDLE.
- Latency: accepted start edge at cycle 0 → prech high in cycles 1..PRECH_CYC; fire in cycle PRECH_CYC+1; WAIT from cycle PRECH_CYC+4.
- Counters saturate at 2^CNT_W-1. They cannot overflow, because trials is at most 2^CNT_W-1.
- decision, tie, p_votes and n_votes change only in DONE or reset. The vote registers update live internally; the outputs present a copy captured at DONE.
- start held high continuously never relaunches; a new 0→1 transition is required.

Test Plan:
- Reset: rst_n=0 for 2 cycles → prech=1, fire=0, busy=0, done=0, decision=0, tie=0, votes=0. Reset asserted during WAIT → IDLE next cycle, no done pulse.
- Single P win: trials=1, start edge at cycle 0; arr_p raised at cycle 10 → prech high cycles 1–4; fire at cycle 5; done 2–3 cycles after arr_p; decision=1, tie=0, p_votes=1, n_votes=0.
- Majority of 5: trials=5 with pattern N,P,N,N,P → five fire pulses, each separated by PRECH_CYC precharge cycles; final p_votes=2, n_votes=3, decision=0, tie=0.
- Timeout and tie: trials=2, no arrivals → each WAIT lasts 64 cycles; done with p_votes=0, n_votes=0, tie=1, decision=0. A second burst with arr_p and arr_n raised in the same cycle gives no vote.
- Ignore rules: arr_p high during PRECH/ARM produces no vote. A start edge while busy produces no second burst. trials=0 runs exactly one trial.
- Back-to-back: new start edge in the cycle after done → second burst proceeds normally; outputs hold the first burst's results until the second done.
